// File: rtl/audio_dac_serializer.sv
// I2S transmitter for the WM8731 DAC path: codec-mastered BCLK/DACLRCK are synchronized into clk,
// stereo pairs are taken over a valid/ready handshake and shifted out MSB-first on DACDAT.
`timescale 1ns / 1ps

module audio_dac_serializer #(
  parameter int unsigned DATA_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] sample_left,
  input  logic [DATA_WIDTH-1:0] sample_right,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  input  logic                  bclk,
  input  logic                  daclrck,
  output logic                  dacdat,
  output logic                  underrun,
  output logic [15:0]           underrun_count
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);
  localparam logic [CntW-1:0] CntIdle = CntW'(DATA_WIDTH);

  logic                  bclk_s1_q, bclk_s2_q, bclk_s3_q;
  logic                  lrck_s1_q, lrck_s2_q;
  logic                  bclk_rise_q, bclk_fall_q;
  logic                  lrck_prev_q, lrck_prev_d;
  logic                  hold_full_q, hold_full_d;
  logic [DATA_WIDTH-1:0] hold_l_q, hold_l_d;
  logic [DATA_WIDTH-1:0] hold_r_q, hold_r_d;
  logic [DATA_WIDTH-1:0] pend_q, pend_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  dacdat_q, dacdat_d;
  logic                  underrun_q, underrun_d;
  logic [15:0]           ur_cnt_q, ur_cnt_d;
  logic                  chan_start, left_start, right_start, handshake;

  // Two-stage synchronizers plus a third stage for edge detection; edge pulses are registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bclk_s1_q   <= 1'b0;
      bclk_s2_q   <= 1'b0;
      bclk_s3_q   <= 1'b0;
      lrck_s1_q   <= 1'b0;
      lrck_s2_q   <= 1'b0;
      bclk_rise_q <= 1'b0;
      bclk_fall_q <= 1'b0;
    end else begin
      bclk_s1_q   <= bclk;
      bclk_s2_q   <= bclk_s1_q;
      bclk_s3_q   <= bclk_s2_q;
      lrck_s1_q   <= daclrck;
      lrck_s2_q   <= lrck_s1_q;
      bclk_rise_q <= bclk_s2_q & ~bclk_s3_q;
      bclk_fall_q <= ~bclk_s2_q & bclk_s3_q;
    end
  end

  always_comb begin
    chan_start  = bclk_rise_q && (lrck_s2_q != lrck_prev_q);
    left_start  = chan_start && !lrck_s2_q;
    right_start = chan_start && lrck_s2_q;
    handshake   = sample_valid && !hold_full_q;

    lrck_prev_d = bclk_rise_q ? lrck_s2_q : lrck_prev_q;
    hold_full_d = hold_full_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    pend_d      = pend_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    dacdat_d    = dacdat_q;
    underrun_d  = 1'b0;
    ur_cnt_d    = ur_cnt_q;

    // A pair accepted alongside an underrunning left start is kept for the next frame.
    if (handshake) begin
      hold_l_d    = sample_left;
      hold_r_d    = sample_right;
      hold_full_d = 1'b1;
    end

    if (left_start) begin
      cnt_d = '0;
      if (hold_full_q) begin
        shift_d     = hold_l_q;
        pend_d      = hold_r_q;
        hold_l_d    = '0;
        hold_r_d    = '0;
        hold_full_d = 1'b0;
      end else begin
        shift_d    = '0;
        pend_d     = '0;
        underrun_d = 1'b1;
        if (ur_cnt_q != 16'hFFFF) ur_cnt_d = ur_cnt_q + 16'd1;
      end
    end else if (right_start) begin
      shift_d = pend_q;
      cnt_d   = '0;
    end else if (bclk_fall_q) begin
      if (cnt_q < CntIdle) begin
        dacdat_d = shift_q[DATA_WIDTH-1];
        shift_d  = {shift_q[DATA_WIDTH-2:0], 1'b0};
        cnt_d    = cnt_q + 1'b1;
      end else begin
        dacdat_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lrck_prev_q <= 1'b0;
      hold_full_q <= 1'b0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      pend_q      <= '0;
      shift_q     <= '0;
      cnt_q       <= CntIdle;
      dacdat_q    <= 1'b0;
      underrun_q  <= 1'b0;
      ur_cnt_q    <= '0;
    end else begin
      lrck_prev_q <= lrck_prev_d;
      hold_full_q <= hold_full_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      pend_q      <= pend_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      dacdat_q    <= dacdat_d;
      underrun_q  <= underrun_d;
      ur_cnt_q    <= ur_cnt_d;
    end
  end

  assign sample_ready   = ~hold_full_q;
  assign dacdat         = dacdat_q;
  assign underrun       = underrun_q;
  assign underrun_count = ur_cnt_q;

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Bench for audio_dac_serializer: models the codec as I2S master, decodes DACDAT per frame and
// compares against a queue of per-frame expected words filled as stimulus is driven.
`timescale 1ns / 1ps

module tb_audio_dac_serializer;

  localparam int unsigned Dw    = 24;
  localparam int unsigned BHalf = 160;
  localparam int unsigned BPer  = 2 * BHalf;

  typedef struct {
    int unsigned frame;
    logic [23:0] l;
    logic [23:0] r;
    bit          check_l;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [Dw-1:0] sample_left = '0;
  logic [Dw-1:0] sample_right = '0;
  logic          sample_valid = 1'b0;
  logic          sample_ready;
  logic          bclk;
  logic          daclrck;
  logic          dacdat;
  logic          underrun;
  logic [15:0]   underrun_count;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned gen_frame = 0;
  int unsigned ur_pulses = 0;
  exp_t        exp_q[$];
  event        left_edge;

  audio_dac_serializer #(.DATA_WIDTH(Dw)) dut (
    .clk            (clk),
    .reset          (reset),
    .sample_left    (sample_left),
    .sample_right   (sample_right),
    .sample_valid   (sample_valid),
    .sample_ready   (sample_ready),
    .bclk           (bclk),
    .daclrck        (daclrck),
    .dacdat         (dacdat),
    .underrun       (underrun),
    .underrun_count (underrun_count)
  );

  always #10 clk = ~clk;

  // Codec master: 32 BCLKs per slot, DACLRCK changes on a BCLK falling edge.
  initial begin
    int unsigned slot_cnt;
    slot_cnt = 0;
    bclk     = 1'b0;
    daclrck  = 1'b1;
    forever begin
      #(BHalf) bclk = 1'b1;
      #(BHalf) bclk = 1'b0;
      slot_cnt++;
      if (slot_cnt == 32) begin
        slot_cnt = 0;
        daclrck  = ~daclrck;
        if (!daclrck) begin
          gen_frame++;
          -> left_edge;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic finalize(input int unsigned n, input logic [23:0] l, input logic [23:0] r,
                          input logic tail);
    exp_t e;
    if (exp_q.size() != 0 && exp_q[0].frame <= n) begin
      e = exp_q.pop_front();
      check("frame_number", n, e.frame);
      if (e.check_l) check("left_word", {8'h0, l}, {8'h0, e.l});
      check("right_word", {8'h0, r}, {8'h0, e.r});
      check("slot_tail_zero", {31'h0, tail}, 32'h0);
    end
  endtask

  // Receiver: bits on BCLK rises 2..25 of each slot form the word; rise 1 and 26..32 must be 0.
  logic        mon_lr = 1'b1;
  int unsigned idx = 0;
  logic [23:0] l_acc = '0;
  logic [23:0] r_acc = '0;
  logic        tail_or = 1'b0;

  always @(posedge bclk) begin
    if (daclrck !== mon_lr) begin
      mon_lr = daclrck;
      idx    = 1;
    end else begin
      idx++;
    end
    if (idx == 1 || idx > 25) tail_or = tail_or | dacdat;
    else if (mon_lr == 1'b0) l_acc = {l_acc[22:0], dacdat};
    else r_acc = {r_acc[22:0], dacdat};
    if (idx == 1 && mon_lr == 1'b0) begin
      finalize(gen_frame - 1, l_acc, r_acc, tail_or);
      l_acc   = '0;
      r_acc   = '0;
      tail_or = 1'b0;
    end
  end

  logic ur_prev = 1'b0;
  always @(negedge clk) begin
    if (underrun) begin
      ur_pulses++;
      check("underrun_width", {31'h0, ur_prev}, 32'h0);
    end
    ur_prev = underrun;
  end

  task automatic send_pair(input logic [23:0] l, input logic [23:0] r, input bit drop,
                           output int unsigned hs_frame);
    int unsigned n;
    bit          done;
    n            = 0;
    done         = 1'b0;
    sample_left  = l;
    sample_right = r;
    sample_valid = 1'b1;
    while (!done && n < 4000) begin
      @(posedge clk);
      n++;
      if (sample_ready) done = 1'b1;
    end
    hs_frame = gen_frame;
    #1;
    if (drop) sample_valid = 1'b0;
    check("handshake_done", {31'h0, done}, 32'h1);
  endtask

  task automatic push(input int unsigned f, input logic [23:0] l, input logic [23:0] r,
                      input bit check_l);
    exp_t e;
    e.frame   = f;
    e.l       = l;
    e.r       = r;
    e.check_l = check_l;
    exp_q.push_back(e);
  endtask

  task automatic wait_frame(input int unsigned n);
    while (gen_frame < n) @(left_edge);
    #(2 * BPer);
  endtask

  initial begin
    int unsigned hs;
    int unsigned f0;

    // Reset values.
    #50;
    check("rst_dacdat", {31'h0, dacdat}, 32'h0);
    check("rst_ready", {31'h0, sample_ready}, 32'h1);
    check("rst_underrun", {31'h0, underrun}, 32'h0);
    check("rst_count", {16'h0, underrun_count}, 32'h0);
    #50 reset = 1'b0;

    // Single pair ahead of the first left start, then three starved frames.
    send_pair(24'hA5C3F1, 24'h123456, 1'b1, hs);
    push(1, 24'hA5C3F1, 24'h123456, 1'b1);
    for (int f = 2; f <= 4; f++) push(f, 24'h0, 24'h0, 1'b1);
    wait_frame(4);
    check("starve_count", {16'h0, underrun_count}, 32'd3);
    check("starve_pulses", ur_pulses, 32'd3);

    // Streaming with valid held high.
    f0 = 0;
    for (int i = 1; i <= 8; i++) begin
      send_pair(24'(i), 24'h800000 | 24'(i), i == 8, hs);
      if (i == 1) f0 = hs;
      else check("stream_hs_frame", hs, f0 + i - 1);
      push(f0 + i, 24'(i), 24'h800000 | 24'(i), 1'b1);
    end
    push(f0 + 9, 24'h0, 24'h0, 1'b1);
    wait_frame(f0 + 8);
    check("stream_count", {16'h0, underrun_count}, 32'd3);

    // Late handshake: valid first seen in the clk that acts on the left start.
    while (gen_frame < f0 + 10) @(left_edge);
    @(posedge bclk);
    repeat (3) @(posedge clk);
    #1;
    sample_left  = 24'h7E5A3C;
    sample_right = 24'hC3A5E7;
    sample_valid = 1'b1;
    @(posedge clk);
    #1;
    check("late_underrun_hi", {31'h0, underrun}, 32'h1);
    check("late_ready_lo", {31'h0, sample_ready}, 32'h0);
    sample_valid = 1'b0;
    @(posedge clk);
    #1;
    check("late_underrun_lo", {31'h0, underrun}, 32'h0);
    push(f0 + 10, 24'h0, 24'h0, 1'b1);
    push(f0 + 11, 24'h7E5A3C, 24'hC3A5E7, 1'b1);
    wait_frame(f0 + 11);
    check("late_count", {16'h0, underrun_count}, 32'd5);

    // Reset in the middle of a left word.
    send_pair(24'hFFFFFF, 24'h5A5A5A, 1'b1, hs);
    while (gen_frame < f0 + 12) @(left_edge);
    #(10 * BPer + 7);
    check("pre_reset_dacdat", {31'h0, dacdat}, 32'h1);
    reset = 1'b1;
    #1;
    check("async_reset_dacdat", {31'h0, dacdat}, 32'h0);
    #99 reset = 1'b0;
    #1;
    check("post_rst_ready", {31'h0, sample_ready}, 32'h1);
    check("post_rst_count", {16'h0, underrun_count}, 32'h0);
    ur_pulses = 0;
    send_pair(24'h3C0F96, 24'h69A5C3, 1'b1, hs);
    push(f0 + 12, 24'h0, 24'h0, 1'b0);
    push(f0 + 13, 24'h3C0F96, 24'h69A5C3, 1'b1);
    wait_frame(f0 + 13);
    check("resume_count", {16'h0, underrun_count}, 32'h0);
    check("resume_pulses", ur_pulses, 32'h0);

    while (gen_frame < f0 + 14) @(left_edge);
    #(2 * BPer);
    check("scoreboard_drained", exp_q.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
